idu_stage: RTL
==============

Name: idu_stage

Overview:
- Registered, parametrised instruction-decode stage. Sits between IFU and EXU in the NPC core.
- Decodes RV32I/RV64I plus optional M-extension into a one-hot micro-op packet.
- Buffers the packet in a 2-entry skid so that EXU ready has no combinational path back to IFU.
- Issues a registered redirect for jalr, ecall and mret, and supports pipeline flush.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64. At 32, W-ops, ld, sd and lwu decode as illegal.
- HAS_M, 1, enables the mul/div/rem family. At 0, these decode as illegal.
- RESET_PC, 0, reset value of redir_pc_o.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  squash all buffered instructions; from EXU branch resolution.
- in_valid_i  in  1  IFU instruction valid.
- in_ready_o  out  1  stage can accept; driven from a register only.
- inst_i  in  32  instruction word.
- pc_i  in  XLEN  instruction PC.
- src1_i  in  XLEN  rs1 value for jalr target, sampled at accept.
- csr_data_i  in  XLEN  mtvec/mepc value for ecall/mret, sampled at accept.
- out_valid_o  out  1  micro-op valid to EXU.
- out_ready_i  in  1  EXU accepts.
- out_uop_o  out  $bits(uop_t)  decoded packet:
  - alu, branch, load and store one-hots
  - rd, rs1, rs2, imm, pc
  - wen_reg, wen_csr, ren_mem, wen_mem
  - mask, load_signed, is_word, illegal
- redir_valid_o  out  1  one-cycle redirect pulse to IFU.
- redir_pc_o  out  XLEN  redirect target.

Behaviour:
- Reset values:
  - out_valid_o=0, redir_valid_o=0, redir_pc_o=RESET_PC.
  - in_ready_o=1, out_uop_o all-zero.
  - State is EMPTY.
- Decode is combinational on inst_i and is captured on accept (in_valid_i & in_ready_o & ~flush_i).
  - Latency is accept to out_valid_o in 1 cycle.
- Immediates are sign-extended to XLEN. The imm format is selected by opcode (I/S/B/U/J).
- Skid FSM has three states: EMPTY, ONE (main valid), TWO (main+skid valid).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & out_ready_i -> ONE; main is reloaded.
    - accept & ~out_ready_i -> TWO; the new packet goes to skid.
    - ~accept & out_ready_i -> EMPTY.
  - TWO:
    - out_ready_i -> ONE; skid moves to main.
    - No accept is possible in TWO.
- in_ready_o is registered and is 0 exactly when next state is TWO or a redirect is pending. in_valid_i must not be accepted while in_ready_o=0.
- out_valid_o = (state != EMPTY). out_uop_o is always the main register, so FIFO order is preserved.
- Illegal decode (unknown opcode/func, or gated by XLEN/HAS_M):
  - uop.illegal=1.
  - All one-hots are 0.
  - wen_reg, ren_mem and wen_mem are 0.
  - The packet still flows through the stage normally.
- wen_reg = ~(branch | store | illegal) & (rd != 0).
- wen_csr = csrrw | csrrs | ecall | mret.
- Redirect:
  - On accept of jalr, ecall or mret, redir_valid_o=1 in the next cycle, for exactly 1 cycle.
  - redir_pc_o = jalr ? ((src1_i + imm) & ~1) : csr_data_i, using values captured at accept. The add wraps modulo 2^XLEN.
  - redir_pc_o holds its value after the pulse.
  - in_ready_o is forced to 0 during the redirect cycle. IFU drops its wrong-path fetch on redir_valid_o.
- Flush:
  - flush_i clears main, skid and any pending redirect on the next edge; state becomes EMPTY and in_ready_o becomes 1.
  - An input offered in the same cycle as flush_i is not accepted.
  - Flush has priority over accept, out_ready_i and redirect.
- Asynchronous reset mid-operation: all state is dropped immediately and nothing is replayed.
- When XLEN=32, RV64 ops (addw, ld, sd, lwu, ...) decode as illegal.

Decomposition:
- Package idu_pkg holds:
  - Opcode constants.
  - Typedefs alu_op_t, branch_op_t, load_op_t, store_op_t, mask_t and uop_t.
  - Mask constants (BYTE/HALF/WORD/DOUBLE).
- Sub-module idu_decode is pure combinational: inst -> uop_t (without pc), parametrised by XLEN and HAS_M.
- idu_stage instantiates idu_decode and owns the skid FSM and redirect register.

Test Plan:
- Reset check: hold reset_n=0, then release -> out_valid_o=0, in_ready_o=1, redir_valid_o=0, redir_pc_o=RESET_PC.
- Basic decode: offer addi x1,x0,5 (0x00500093) at pc 0x80000000 with out_ready_i=1 -> next cycle out_valid_o=1, alu.add=1, imm=5, rd=1, wen_reg=1.
- Backpressure:
  - Hold out_ready_i=0 and offer 2 instructions back to back -> state TWO, in_ready_o=0.
  - Raise out_ready_i -> both instructions emerge in order over 2 cycles, with no loss or duplication.
- Jalr redirect: offer jalr x0,3(x5) with src1_i=0x1000 -> redir_valid_o pulses 1 cycle later with redir_pc_o=0x1002; in_ready_o=0 during that cycle.
- Flush while full:
  - In state TWO, assert flush_i with in_valid_i=1 -> next cycle out_valid_o=0, in_ready_o=1.
  - The offered instruction does not appear.
- Parameter gating:
  - XLEN=32: addw (0x002080BB) -> illegal=1, wen_reg=0.
  - HAS_M=0: mul (0x022080B3) -> illegal=1.
  - XLEN=64, HAS_M=1: mul -> alu.mul=1.

Source files
------------

// File: rtl/idu_pkg.sv
// idu_pkg: opcodes, micro-op types and access-mask constants shared by the decode stage
package idu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef logic [7:0] mask_t;

  localparam mask_t MASK_BYTE   = 8'h01;
  localparam mask_t MASK_HALF   = 8'h03;
  localparam mask_t MASK_WORD   = 8'h0f;
  localparam mask_t MASK_DOUBLE = 8'hff;

  typedef struct packed {
    logic add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
    logic lui, auipc, jal, jalr;
    logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
    logic csrrw, csrrs, ecall, mret;
  } alu_op_t;

  typedef struct packed {
    logic beq, bne, blt, bge, bltu, bgeu;
  } branch_op_t;

  typedef struct packed {
    logic lb, lh, lw, ld, lbu, lhu, lwu;
  } load_op_t;

  typedef struct packed {
    logic sb, sh, sw, sd;
  } store_op_t;

  // imm and pc are carried at 64 bits; at XLEN=32 the upper half is zero
  typedef struct packed {
    alu_op_t    alu;
    branch_op_t branch;
    load_op_t   load;
    store_op_t  store;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic [63:0] pc;
    logic        wen_reg;
    logic        wen_csr;
    logic        ren_mem;
    logic        wen_mem;
    mask_t       mask;
    logic        load_signed;
    logic        is_word;
    logic        illegal;
  } uop_t;

endpackage

// File: rtl/idu_decode.sv
// idu_decode: combinational instruction word to micro-op decode (pc left zero)
module idu_decode
  import idu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1
) (
  input  logic [31:0] inst,
  output uop_t        uop
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [7:0]  f3h;
  logic        f7z, f7s, f7m, sh_ok, sra_ok, m_ok, legal;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm64;
  alu_op_t     a;
  branch_op_t  b;
  load_op_t    l;
  store_op_t   s;

  assign opc    = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign f3h    = 8'b1 << f3;
  assign f7z    = (f7 == 7'h00);
  assign f7s    = (f7 == 7'h20);
  assign f7m    = (f7 == 7'h01);
  assign m_ok   = HAS_M & f7m;
  assign sh_ok  = RV64 ? (f7[6:1] == 6'b000000) : f7z;
  assign sra_ok = RV64 ? (f7[6:1] == 6'b010000) : f7s;
  assign imm_i  = {{52{inst[31]}}, inst[31:20]};
  assign imm_s  = {{52{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {{32{inst[31]}}, inst[31:12], 12'b0};
  assign imm_j  = {{44{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // opcode/funct decode into one-hots; anything left all-zero is illegal
  always_comb begin
    a = '0;
    b = '0;
    l = '0;
    s = '0;
    imm64 = '0;
    case (opc)
      OP_LUI:    begin a.lui = 1'b1; imm64 = imm_u; end
      OP_AUIPC:  begin a.auipc = 1'b1; imm64 = imm_u; end
      OP_JAL:    begin a.jal = 1'b1; imm64 = imm_j; end
      OP_JALR:   begin a.jalr = f3h[0]; imm64 = imm_i; end
      OP_BRANCH: begin
        imm64 = imm_b;
        b = '{beq: f3h[0], bne: f3h[1], blt: f3h[4], bge: f3h[5], bltu: f3h[6], bgeu: f3h[7]};
      end
      OP_LOAD:   begin
        imm64 = imm_i;
        l = '{lb: f3h[0], lh: f3h[1], lw: f3h[2], ld: RV64 & f3h[3], lbu: f3h[4], lhu: f3h[5], lwu: RV64 & f3h[6]};
      end
      OP_STORE:  begin
        imm64 = imm_s;
        s = '{sb: f3h[0], sh: f3h[1], sw: f3h[2], sd: RV64 & f3h[3]};
      end
      OP_IMM:    begin
        imm64 = imm_i;
        a.add = f3h[0];
        a.sll = f3h[1] & sh_ok;
        a.slt = f3h[2];
        a.sltu = f3h[3];
        a.xor_op = f3h[4];
        a.srl = f3h[5] & sh_ok;
        a.sra = f3h[5] & sra_ok;
        a.or_op = f3h[6];
        a.and_op = f3h[7];
      end
      OP_IMM32:  begin
        imm64 = imm_i;
        a.add = RV64 & f3h[0];
        a.sll = RV64 & f3h[1] & f7z;
        a.srl = RV64 & f3h[5] & f7z;
        a.sra = RV64 & f3h[5] & f7s;
      end
      OP_REG:    begin
        a.add = f7z & f3h[0];
        a.sub = f7s & f3h[0];
        a.sll = f7z & f3h[1];
        a.slt = f7z & f3h[2];
        a.sltu = f7z & f3h[3];
        a.xor_op = f7z & f3h[4];
        a.srl = f7z & f3h[5];
        a.sra = f7s & f3h[5];
        a.or_op = f7z & f3h[6];
        a.and_op = f7z & f3h[7];
        a.mul = m_ok & f3h[0];
        a.mulh = m_ok & f3h[1];
        a.mulhsu = m_ok & f3h[2];
        a.mulhu = m_ok & f3h[3];
        a.div = m_ok & f3h[4];
        a.divu = m_ok & f3h[5];
        a.rem = m_ok & f3h[6];
        a.remu = m_ok & f3h[7];
      end
      OP_REG32:  begin
        a.add = RV64 & f7z & f3h[0];
        a.sub = RV64 & f7s & f3h[0];
        a.sll = RV64 & f7z & f3h[1];
        a.srl = RV64 & f7z & f3h[5];
        a.sra = RV64 & f7s & f3h[5];
        a.mul = RV64 & m_ok & f3h[0];
        a.div = RV64 & m_ok & f3h[4];
        a.divu = RV64 & m_ok & f3h[5];
        a.rem = RV64 & m_ok & f3h[6];
        a.remu = RV64 & m_ok & f3h[7];
      end
      OP_SYSTEM: begin
        imm64 = imm_i;
        a.ecall = (inst == 32'h0000_0073);
        a.mret = (inst == 32'h3020_0073);
        a.csrrw = f3h[1];
        a.csrrs = f3h[2];
      end
      default: ;
    endcase
  end

  assign legal = |{a, b, l, s};

  // assemble the packet and derive enables, mask and flags from the one-hots
  always_comb begin
    uop = '0;
    uop.alu = a;
    uop.branch = b;
    uop.load = l;
    uop.store = s;
    uop.rd = inst[11:7];
    uop.rs1 = inst[19:15];
    uop.rs2 = inst[24:20];
    uop.imm = RV64 ? imm64 : {32'b0, imm64[31:0]};
    uop.wen_reg = legal & ~(|b) & ~(|s) & (inst[11:7] != 5'd0);
    uop.wen_csr = a.csrrw | a.csrrs | a.ecall | a.mret;
    uop.ren_mem = |l;
    uop.wen_mem = |s;
    uop.mask = ~(|l | |s) ? '0 : f3[1:0] == 2'd0 ? MASK_BYTE : f3[1:0] == 2'd1 ? MASK_HALF : f3[1:0] == 2'd2 ? MASK_WORD : MASK_DOUBLE;
    uop.load_signed = |l & ~f3[2];
    uop.is_word = legal & ((opc == OP_IMM32) | (opc == OP_REG32));
    uop.illegal = ~legal;
  end

endmodule

// File: rtl/idu_stage.sv
// idu_stage: registered decode stage with 2-entry skid buffer, redirect and flush
module idu_stage
  import idu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter bit              HAS_M    = 1'b1,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] csr_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output uop_t            out_uop_o,
  output logic            redir_valid_o,
  output logic [XLEN-1:0] redir_pc_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state, state_d;
  uop_t            dec, pkt, main_q, skid_q, main_d, skid_d;
  logic            accept, redir_d;
  logic [XLEN-1:0] tgt;

  idu_decode #(.XLEN(XLEN), .HAS_M(HAS_M)) u_dec (.inst(inst_i), .uop(dec));

  assign accept      = in_valid_i & in_ready_o & ~flush_i;
  assign redir_d     = accept & (dec.alu.jalr | dec.alu.ecall | dec.alu.mret);
  assign tgt         = dec.alu.jalr ? (src1_i + dec.imm[XLEN-1:0]) & ~XLEN'(1) : csr_data_i;
  assign out_valid_o = (state != EMPTY);
  assign out_uop_o   = main_q;

  // attach the fetch pc to the decoded packet
  always_comb begin
    pkt = dec;
    pkt.pc = 64'(pc_i);
  end

  // skid FSM: main always feeds EXU, skid only fills when EXU stalls in ONE
  always_comb begin
    state_d = state;
    main_d = main_q;
    skid_d = skid_q;
    case (state)
      EMPTY: if (accept) begin state_d = ONE; main_d = pkt; end
      ONE: begin
        if (accept & out_ready_i) main_d = pkt;
        else if (accept) begin state_d = TWO; skid_d = pkt; end
        else if (out_ready_i) state_d = EMPTY;
      end
      default: if (out_ready_i) begin state_d = ONE; main_d = skid_q; end
    endcase
    if (flush_i) begin
      state_d = EMPTY;
      main_d = '0;
      skid_d = '0;
    end
  end

  // state, buffers, registered ready and the redirect pulse/target
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready_o <= 1'b1;
      redir_valid_o <= 1'b0;
      redir_pc_o <= RESET_PC;
    end else begin
      state <= state_d;
      main_q <= main_d;
      skid_q <= skid_d;
      in_ready_o <= (state_d != TWO) & ~redir_d;
      redir_valid_o <= redir_d;
      if (redir_d) redir_pc_o <= tgt;
    end
  end

endmodule
